// File: rtl/ysyx_22040931_mem_stage.sv
// ---------------------------------------------------------------------------
// ysyx_22040931_mem_stage
//   Memory-access stage of the 5-stage core. Accepts one instruction at a time
//   from EX and forwards a registered write-back triple plus pc to WB.
//   Non-memory and misaligned instructions pass through in one cycle. Aligned
//   loads and stores go through a valid/ready request to data memory and then
//   wait for a response.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   ex_*_i / ex_ready_o   instruction handoff from EX (valid/ready)
//   dmem_req_*            memory request: valid/ready, address, wen, wdata, wmask
//   dmem_resp_*           memory response: valid strobe and aligned read data
//   wb_valid_o, w_*_o     registered write-back triple, valid for one cycle
//   pc_o                  pc of the instruction in the write-back slot
//   misalign_o            write-back slot holds a misaligned access
// ---------------------------------------------------------------------------
module ysyx_22040931_mem_stage #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              w_ena_i,
  input  logic [4:0]        w_addr_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic              mem_ren_i,
  input  logic              mem_wen_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic              dmem_wen_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  output logic [7:0]        dmem_wmask_o,
  input  logic              dmem_resp_valid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  output logic              w_ena_o,
  output logic [4:0]        w_addr_o,
  output logic [DATA_W-1:0] w_data_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e state_q;

  // Captured memory instruction (held from accept until the response)
  logic [DATA_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wmask_q;
  logic [2:0]        off_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              w_ena_cap_q;
  logic [4:0]        w_addr_cap_q;
  logic [PC_W-1:0]   pc_cap_q;

  // Registered write-back slot
  logic              wb_valid_q;
  logic              w_ena_q;
  logic              misalign_q;
  logic [4:0]        w_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [PC_W-1:0]   pc_q;

  // Decode of the incoming instruction
  logic              accept;
  logic              is_mem;
  logic              is_store;
  logic              misaligned;
  logic              w_ena_gated;
  logic [2:0]        off_i;
  logic [7:0]        wmask_base;
  logic [DATA_W-1:0] wdata_fmt_d;
  logic [7:0]        wmask_fmt_d;
  // Load alignment of the response
  logic [DATA_W-1:0] load_shift;
  logic [DATA_W-1:0] load_ext_d;

  // NOTE: every signal written in always_comb gets a default first so no
  // latch is inferred on any path through the case statements.
  always_comb begin
    off_i       = alu_res_i[2:0];
    accept      = ex_valid_i && (state_q == IDLE);
    is_mem      = mem_ren_i | mem_wen_i;
    // A load wins when both enables are set.
    is_store    = mem_wen_i & ~mem_ren_i;
    w_ena_gated = w_ena_i && (w_addr_i != 5'd0);

    misaligned = 1'b0;
    wmask_base = 8'h00;
    case (mem_size_i)
      2'd0: begin misaligned = 1'b0;             wmask_base = 8'h01; end
      2'd1: begin misaligned = off_i[0];         wmask_base = 8'h03; end
      2'd2: begin misaligned = |off_i[1:0];      wmask_base = 8'h0F; end
      default: begin misaligned = |off_i;        wmask_base = 8'hFF; end
    endcase

    wdata_fmt_d = store_data_i << {off_i, 3'b000};
    wmask_fmt_d = wmask_base << off_i;
  end

  always_comb begin
    load_shift = dmem_rdata_i >> {off_q, 3'b000};
    load_ext_d = load_shift;
    case (size_q)
      2'd0: load_ext_d = {{(DATA_W-8){~unsigned_q & load_shift[7]}},   load_shift[7:0]};
      2'd1: load_ext_d = {{(DATA_W-16){~unsigned_q & load_shift[15]}}, load_shift[15:0]};
      2'd2: load_ext_d = {{(DATA_W-32){~unsigned_q & load_shift[31]}}, load_shift[31:0]};
      default: load_ext_d = load_shift;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      off_q        <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      w_ena_cap_q  <= 1'b0;
      w_addr_cap_q <= '0;
      pc_cap_q     <= '0;
      wb_valid_q   <= 1'b0;
      w_ena_q      <= 1'b0;
      misalign_q   <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      pc_q         <= '0;
    end else begin
      // Write-back pulses last one cycle; data fields hold between pulses.
      wb_valid_q <= 1'b0;
      w_ena_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mem && !misaligned) begin
              state_q      <= REQ;
              addr_q       <= {alu_res_i[DATA_W-1:3], 3'b000};
              wen_q        <= is_store;
              wdata_q      <= wdata_fmt_d;
              wmask_q      <= wmask_fmt_d;
              off_q        <= off_i;
              size_q       <= mem_size_i;
              unsigned_q   <= mem_unsigned_i;
              w_ena_cap_q  <= w_ena_gated;
              w_addr_cap_q <= w_addr_i;
              pc_cap_q     <= pc_i;
            end else begin
              // Non-memory op, or a misaligned access that never reaches memory.
              wb_valid_q <= 1'b1;
              w_ena_q    <= w_ena_gated & ~is_mem;
              misalign_q <= is_mem;
              w_addr_q   <= w_addr_i;
              w_data_q   <= alu_res_i;
              pc_q       <= pc_i;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready_i) state_q <= WAIT;
        end
        WAIT: begin
          if (dmem_resp_valid_i) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b1;
            w_ena_q    <= w_ena_cap_q & ~wen_q;
            w_addr_q   <= w_addr_cap_q;
            pc_q       <= pc_cap_q;
            if (!wen_q) w_data_q <= load_ext_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready_o       = (state_q == IDLE);
  assign dmem_req_valid_o = (state_q == REQ);
  assign dmem_addr_o      = addr_q;
  assign dmem_wen_o       = wen_q;
  assign dmem_wdata_o     = wdata_q;
  assign dmem_wmask_o     = wmask_q;
  assign wb_valid_o       = wb_valid_q;
  assign w_ena_o          = w_ena_q;
  assign w_addr_o         = w_addr_q;
  assign w_data_o         = w_data_q;
  assign pc_o             = pc_q;
  assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_ysyx_22040931_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040931_mem_stage
//   Directed bench for the memory-access stage. Inputs change 1 time unit
//   after the rising edge; outputs are compared at the same point, well away
//   from the next edge.
// ---------------------------------------------------------------------------
module tb_ysyx_22040931_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [63:0] pc_i;
  logic        w_ena_i;
  logic [4:0]  w_addr_i;
  logic [63:0] alu_res_i;
  logic        mem_ren_i;
  logic        mem_wen_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [63:0] store_data_i;
  logic        dmem_req_valid_o;
  logic        dmem_req_ready_i;
  logic [63:0] dmem_addr_o;
  logic        dmem_wen_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wmask_o;
  logic        dmem_resp_valid_i;
  logic [63:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic        w_ena_o;
  logic [4:0]  w_addr_o;
  logic [63:0] w_data_o;
  logic [63:0] pc_o;
  logic        misalign_o;

  int vectors    = 0;
  int miscompares = 0;

  ysyx_22040931_mem_stage #(.DATA_W(64), .PC_W(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_valid_i        (ex_valid_i),
    .ex_ready_o        (ex_ready_o),
    .pc_i              (pc_i),
    .w_ena_i           (w_ena_i),
    .w_addr_i          (w_addr_i),
    .alu_res_i         (alu_res_i),
    .mem_ren_i         (mem_ren_i),
    .mem_wen_i         (mem_wen_i),
    .mem_size_i        (mem_size_i),
    .mem_unsigned_i    (mem_unsigned_i),
    .store_data_i      (store_data_i),
    .dmem_req_valid_o  (dmem_req_valid_o),
    .dmem_req_ready_i  (dmem_req_ready_i),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_wen_o        (dmem_wen_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_wmask_o      (dmem_wmask_o),
    .dmem_resp_valid_i (dmem_resp_valid_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .wb_valid_o        (wb_valid_o),
    .w_ena_o           (w_ena_o),
    .w_addr_o          (w_addr_o),
    .w_data_o          (w_data_o),
    .pc_o              (pc_o),
    .misalign_o        (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid_i     = 1'b0;
    pc_i           = '0;
    w_ena_i        = 1'b0;
    w_addr_i       = '0;
    alu_res_i      = '0;
    mem_ren_i      = 1'b0;
    mem_wen_i      = 1'b0;
    mem_size_i     = 2'd0;
    mem_unsigned_i = 1'b0;
    store_data_i   = '0;
  endtask

  initial begin
    // ---- Reset with a stale response pending ----
    rst = 1'b1;
    clear_ex();
    dmem_req_ready_i  = 1'b0;
    dmem_resp_valid_i = 1'b1;
    dmem_rdata_i      = 64'hDEAD_BEEF_DEAD_BEEF;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_ex_ready", ex_ready_o, 1);
    check("rst_req_valid", dmem_req_valid_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_w_ena", w_ena_o, 0);
    check("rst_w_data", w_data_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_wmask", dmem_wmask_o, 0);
    cycle();
    check("stale_resp_wb_valid", wb_valid_o, 0);
    dmem_resp_valid_i = 1'b0;

    // ---- Non-memory back-to-back ----
    ex_valid_i = 1'b1; w_ena_i = 1'b1; w_addr_i = 5'd5;
    alu_res_i = 64'h10; pc_i = 64'h1000;
    check("nm_ready0", ex_ready_o, 1);
    cycle();
    check("nm0_wb_valid", wb_valid_o, 1);
    check("nm0_data", w_data_o, 64'h10);
    check("nm0_w_ena", w_ena_o, 1);
    check("nm0_w_addr", w_addr_o, 5);
    check("nm0_pc", pc_o, 64'h1000);
    check("nm_ready1", ex_ready_o, 1);
    alu_res_i = 64'h20; pc_i = 64'h1004;
    cycle();
    check("nm1_wb_valid", wb_valid_o, 1);
    check("nm1_data", w_data_o, 64'h20);
    check("nm_ready2", ex_ready_o, 1);
    alu_res_i = 64'h30; pc_i = 64'h1008;
    cycle();
    check("nm2_wb_valid", wb_valid_o, 1);
    check("nm2_data", w_data_o, 64'h30);
    check("nm2_pc", pc_o, 64'h1008);
    clear_ex();
    cycle();
    check("nm_idle_wb_valid", wb_valid_o, 0);
    check("nm_idle_w_ena", w_ena_o, 0);
    check("nm_idle_hold", w_data_o, 64'h30);

    // ---- Signed byte load, minimum latency ----
    ex_valid_i = 1'b1; mem_ren_i = 1'b1; mem_size_i = 2'd0; mem_unsigned_i = 1'b0;
    alu_res_i = 64'h8000_0003; w_ena_i = 1'b1; w_addr_i = 5'd7; pc_i = 64'h2000;
    dmem_req_ready_i = 1'b1;
    dmem_rdata_i = 64'h0000_0000_80FF_0000;
    cycle();                                   // accept
    clear_ex();
    check("lb_req_valid", dmem_req_valid_o, 1);
    check("lb_addr", dmem_addr_o, 64'h8000_0000);
    check("lb_wen", dmem_wen_o, 0);
    check("lb_ex_ready", ex_ready_o, 0);
    cycle();                                   // request accepted
    dmem_req_ready_i = 1'b0;
    dmem_resp_valid_i = 1'b1;
    check("lb_wait_req_valid", dmem_req_valid_o, 0);
    check("lb_wait_wb_valid", wb_valid_o, 0);
    cycle();                                   // response taken
    dmem_resp_valid_i = 1'b0;
    check("lb_wb_valid", wb_valid_o, 1);
    check("lb_data", w_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_w_ena", w_ena_o, 1);
    check("lb_w_addr", w_addr_o, 7);
    check("lb_pc", pc_o, 64'h2000);
    check("lb_ex_ready", ex_ready_o, 1);
    cycle();
    check("lb_pulse", wb_valid_o, 0);

    // ---- Unsigned halfword load, ready withheld 4 cycles ----
    ex_valid_i = 1'b1; mem_ren_i = 1'b1; mem_size_i = 2'd1; mem_unsigned_i = 1'b1;
    alu_res_i = 64'h6; w_ena_i = 1'b1; w_addr_i = 5'd9; pc_i = 64'h3000;
    dmem_rdata_i = 64'hBEEF_0000_0000_0000;
    cycle();
    clear_ex();
    dmem_resp_valid_i = 1'b1;                  // must be ignored while in REQ
    for (int i = 0; i < 4; i++) begin
      check("lhu_stall_req_valid", dmem_req_valid_o, 1);
      check("lhu_stall_addr", dmem_addr_o, 64'h0);
      check("lhu_stall_ex_ready", ex_ready_o, 0);
      cycle();
    end
    check("lhu_stall_wb_valid", wb_valid_o, 0);
    dmem_req_ready_i = 1'b1;
    check("lhu_req_valid5", dmem_req_valid_o, 1);
    check("lhu_addr5", dmem_addr_o, 64'h0);
    cycle();
    dmem_req_ready_i = 1'b0;
    check("lhu_wait_ex_ready", ex_ready_o, 0);
    cycle();
    dmem_resp_valid_i = 1'b0;
    check("lhu_wb_valid", wb_valid_o, 1);
    check("lhu_data", w_data_o, 64'h0000_0000_0000_BEEF);
    check("lhu_w_ena", w_ena_o, 1);

    // ---- Word store at offset 4 ----
    ex_valid_i = 1'b1; mem_wen_i = 1'b1; mem_size_i = 2'd2;
    alu_res_i = 64'h4; store_data_i = 64'h1122_3344; w_ena_i = 1'b0; pc_i = 64'h4000;
    dmem_req_ready_i = 1'b1;
    cycle();
    clear_ex();
    check("sw_req_valid", dmem_req_valid_o, 1);
    check("sw_wmask", dmem_wmask_o, 8'hF0);
    check("sw_wdata", dmem_wdata_o, 64'h1122_3344_0000_0000);
    check("sw_wen", dmem_wen_o, 1);
    check("sw_addr", dmem_addr_o, 64'h0);
    cycle();
    dmem_req_ready_i = 1'b0;
    dmem_resp_valid_i = 1'b1;
    cycle();
    dmem_resp_valid_i = 1'b0;
    check("sw_wb_valid", wb_valid_o, 1);
    check("sw_w_ena", w_ena_o, 0);
    check("sw_pc", pc_o, 64'h4000);

    // ---- Misaligned word load ----
    ex_valid_i = 1'b1; mem_ren_i = 1'b1; mem_size_i = 2'd2;
    alu_res_i = 64'h2; w_ena_i = 1'b1; w_addr_i = 5'd4; pc_i = 64'h5000;
    check("mis_req_before", dmem_req_valid_o, 0);
    cycle();
    clear_ex();
    check("mis_req_valid", dmem_req_valid_o, 0);
    check("mis_ex_ready", ex_ready_o, 1);
    check("mis_wb_valid", wb_valid_o, 1);
    check("mis_flag", misalign_o, 1);
    check("mis_w_ena", w_ena_o, 0);
    cycle();
    check("mis_pulse", misalign_o, 0);
    check("mis_req_after", dmem_req_valid_o, 0);

    // ---- Reset while waiting for a response ----
    ex_valid_i = 1'b1; mem_ren_i = 1'b1; mem_size_i = 2'd3;
    alu_res_i = 64'h8; w_ena_i = 1'b1; w_addr_i = 5'd6; pc_i = 64'h6000;
    dmem_req_ready_i = 1'b1;
    cycle();
    clear_ex();
    cycle();                                   // now in WAIT
    dmem_req_ready_i = 1'b0;
    check("rw_in_wait", ex_ready_o, 0);
    rst = 1'b1;
    #1;
    check("rw_async_ready", ex_ready_o, 1);
    check("rw_async_req", dmem_req_valid_o, 0);
    dmem_resp_valid_i = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("rw_resp_wb_valid", wb_valid_o, 0);
    check("rw_resp_ex_ready", ex_ready_o, 1);
    dmem_resp_valid_i = 1'b0;
    ex_valid_i = 1'b1; w_ena_i = 1'b1; w_addr_i = 5'd3; alu_res_i = 64'h55; pc_i = 64'h7000;
    cycle();
    clear_ex();
    check("rw_nm_wb_valid", wb_valid_o, 1);
    check("rw_nm_data", w_data_o, 64'h55);
    check("rw_nm_w_addr", w_addr_o, 3);

    // ---- Doubleword load to x0 with wen also set (load wins) ----
    ex_valid_i = 1'b1; mem_ren_i = 1'b1; mem_wen_i = 1'b1; mem_size_i = 2'd3;
    mem_unsigned_i = 1'b1; alu_res_i = 64'h10; w_ena_i = 1'b1; w_addr_i = 5'd0;
    pc_i = 64'h8000;
    dmem_req_ready_i = 1'b1;
    dmem_rdata_i = 64'h8123_4567_89AB_CDEF;
    cycle();
    clear_ex();
    check("x0_req_valid", dmem_req_valid_o, 1);
    check("x0_wen", dmem_wen_o, 0);
    check("x0_addr", dmem_addr_o, 64'h10);
    cycle();
    dmem_req_ready_i = 1'b0;
    dmem_resp_valid_i = 1'b1;
    cycle();
    dmem_resp_valid_i = 1'b0;
    check("x0_wb_valid", wb_valid_o, 1);
    check("x0_w_ena", w_ena_o, 0);
    check("x0_data", w_data_o, 64'h8123_4567_89AB_CDEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22040931_mem_stage.md
Name: ysyx_22040931_mem_stage

Overview:
- Memory-access stage of the 5-stage core, directly upstream of the write-back stage.
- Accepts one instruction at a time from EX and issues loads and stores to the data-memory port with a valid/ready request and response handshake.
- Aligns and extends load data and registers the write-back triple (w_ena, w_addr, w_data) plus pc.
- WB is purely combinational and always accepts, so this block has no downstream backpressure.

Parameters:
- DATA_W, 64, register/data width
- PC_W, 64, program-counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ex_valid_i  in  1  EX presents an instruction
- ex_ready_o  out  1  stage can accept an instruction
- pc_i  in  PC_W  instruction pc
- w_ena_i  in  1  instruction writes rd
- w_addr_i  in  5  rd index
- alu_res_i  in  DATA_W  ALU result / effective address
- mem_ren_i  in  1  load
- mem_wen_i  in  1  store
- mem_size_i  in  2  0=B, 1=H, 2=W, 3=D
- mem_unsigned_i  in  1  zero-extend load
- store_data_i  in  DATA_W  rs2 value
- dmem_req_valid_o  out  1  memory request valid
- dmem_req_ready_i  in  1  memory accepts request
- dmem_addr_o  out  DATA_W  address, bits[2:0] forced to 0
- dmem_wen_o  out  1  request is a write
- dmem_wdata_o  out  DATA_W  lane-shifted store data
- dmem_wmask_o  out  8  byte-enable
- dmem_resp_valid_i  in  1  read data / write ack
- dmem_rdata_i  in  DATA_W  aligned doubleword
- wb_valid_o  out  1  WB outputs valid this cycle
- w_ena_o  out  1  to WB
- w_addr_o  out  5  to WB
- w_data_o  out  DATA_W  to WB
- pc_o  out  PC_W  to WB
- misalign_o  out  1  instruction in wb slot was a misaligned access

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0 except ex_ready_o=1; captured instruction is discarded.
- FSM states: IDLE, REQ, WAIT.
- ex_ready_o = (state==IDLE). An instruction is accepted on ex_valid_i & ex_ready_o.
- Load priority: if mem_ren_i and mem_wen_i are both set, the instruction is a load and wen is ignored.
- Non-memory instruction:
  - Stay in IDLE.
  - Next cycle: wb_valid_o=1, w_data_o=alu_res_i, w_addr_o=w_addr_i, pc_o=pc_i.
  - Throughput is 1 instruction per cycle.
- w_ena_o = w_ena_i & (w_addr_i!=0) on every path. A load to x0 still performs the access.
- Misaligned access:
  - Condition: H with off[0]!=0; W with off[1:0]!=0; D with off!=0, where off=alu_res_i[2:0].
  - No memory request; stay in IDLE.
  - Next cycle: wb_valid_o=1, w_ena_o=0, misalign_o=1.
- Aligned memory op:
  - IDLE→REQ on accept; the instruction is captured.
  - REQ: dmem_req_valid_o=1. Address, wen, wdata and wmask are held stable until dmem_req_ready_i. On ready: REQ→WAIT.
  - WAIT: dmem_resp_valid_i is honoured no earlier than the cycle after request acceptance. On resp: WAIT→IDLE.
  - The cycle after resp: wb_valid_o=1.
  - Load: w_data_o = extend(dmem_rdata_i >> 8*off).
  - Store: w_ena_o=0.
  - Minimum latency is accept→wb_valid_o = 3 cycles (req ready same cycle, resp next).
- Store formatting:
  - dmem_wdata_o = store_data_i << 8*off.
  - dmem_wmask_o = {0x01, 0x03, 0x0F, 0xFF}[size] << off.
- Load extension:
  - Take the low 8/16/32/64 bits.
  - Sign-extend unless mem_unsigned_i. Size D ignores mem_unsigned_i.
- wb_valid_o and misalign_o are single-cycle pulses per instruction.
- When wb_valid_o=0: w_ena_o=0; w_addr_o, w_data_o and pc_o hold their last values.
- dmem_resp_valid_i in IDLE or REQ is ignored, including a stale response after reset.
- dmem_req_valid_o is never deasserted before ready except by rst.

Test Plan:
- Non-memory back-to-back: ex_valid_i held 3 cycles, alu_res_i = 0x10, 0x20, 0x30, w_addr_i = 5 -> wb_valid_o high 3 consecutive cycles with w_data_o = 0x10, 0x20, 0x30; ex_ready_o stays 1.
- Signed byte load:
  - Stimulus: addr 0x80000003, size B, unsigned=0; dmem_rdata_i = 0x00000000_80FF0000; ready same cycle; resp one cycle later.
  - Response: dmem_addr_o=0x80000000; w_data_o=0xFFFFFFFF_FFFFFF80 (byte 3 = 0x80); wb_valid_o 3 cycles after accept.
- Unsigned halfword load with stall:
  - Stimulus: addr 0x6, LHU; ready withheld 4 cycles; dmem_rdata_i = 0xBEEF_0000_0000_0000.
  - Response: dmem_req_valid_o and address stable 5 cycles; ex_ready_o=0 throughout; w_data_o=0x000000000000BEEF.
- Word store: addr 0x4, SW, store_data_i=0x11223344 -> dmem_wmask_o=0xF0, dmem_wdata_o=0x11223344_00000000, dmem_wen_o=1; on ack, wb_valid_o=1 with w_ena_o=0.
- Misaligned: LW at 0x2 -> no dmem_req_valid_o; the next cycle has wb_valid_o=1, misalign_o=1, w_ena_o=0.
- Reset in WAIT: rst pulsed while awaiting a response, then dmem_resp_valid_i=1 arrives -> state IDLE, wb_valid_o stays 0, ex_ready_o=1, and the next non-memory op completes normally. Also cover a load to x0: w_ena_o=0.
